// File: rtl/frogger_level_sequencer.sv
// Frogger level sequencer: start/level/win/game-over control plus the per-level lane tick.
// Tick period halves with every level; outputs decode only registered state.
module frogger_level_sequencer #(
  parameter int unsigned LEVELS_DATAWIDTH    = 2,
  parameter int unsigned MAX_LEVEL           = 3,
  parameter int unsigned PRESCALER_DATAWIDTH = 24,
  parameter int unsigned BASE_PERIOD         = 8000000
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET_InHigh,
  input  logic                        start_InLow,
  input  logic                        goal_InHigh,
  input  logic                        game_over_InLow,
  output logic [LEVELS_DATAWIDTH-1:0] level_OutBUS,
  output logic                        tick_OutHigh,
  output logic                        level_up_OutHigh,
  output logic                        win_OutLow,
  output logic                        playing_OutHigh
);

  typedef enum logic [2:0] {
    StIdle,
    StPlaying,
    StLevelUp,
    StWin,
    StOver
  } stateType;

  localparam logic [PRESCALER_DATAWIDTH-1:0] BasePeriod = PRESCALER_DATAWIDTH'(BASE_PERIOD);
  localparam logic [LEVELS_DATAWIDTH-1:0]    MaxLevel   = LEVELS_DATAWIDTH'(MAX_LEVEL);

  stateType                       stateQ, stateD;
  logic [LEVELS_DATAWIDTH-1:0]    levelQ, levelD;
  logic [PRESCALER_DATAWIDTH-1:0] counterQ, counterD;
  logic                           startPrevQ;
  logic                           startEvent;
  logic [PRESCALER_DATAWIDTH-1:0] period;
  logic                           tickHit;

  assign startEvent = !start_InLow && startPrevQ;

  // High levels can shift the period down to zero; clamp so the tick fires every cycle.
  always_comb begin
    period = BasePeriod >> levelQ;
    if (period == '0) begin
      period = PRESCALER_DATAWIDTH'(1);
    end
  end

  assign tickHit = (counterQ == period - PRESCALER_DATAWIDTH'(1));

  always_comb begin
    stateD   = stateQ;
    levelD   = levelQ;
    counterD = '0;
    case (stateQ)
      StIdle, StWin, StOver: begin
        if (startEvent) begin
          stateD = StPlaying;
          levelD = '0;
        end
      end
      StPlaying: begin
        if (!game_over_InLow) begin
          stateD = StOver;
        end else if (goal_InHigh) begin
          if (levelQ == MaxLevel) begin
            stateD = StWin;
          end else begin
            stateD = StLevelUp;
            levelD = levelQ + LEVELS_DATAWIDTH'(1);
          end
        end else if (!tickHit) begin
          counterD = counterQ + PRESCALER_DATAWIDTH'(1);
        end
      end
      StLevelUp: begin
        stateD = StPlaying;
      end
      default: begin
        stateD = StIdle;
        levelD = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      stateQ     <= StIdle;
      levelQ     <= '0;
      counterQ   <= '0;
      startPrevQ <= 1'b1;
    end else begin
      stateQ     <= stateD;
      levelQ     <= levelD;
      counterQ   <= counterD;
      startPrevQ <= start_InLow;
    end
  end

  assign level_OutBUS     = levelQ;
  assign tick_OutHigh     = (stateQ == StPlaying) && tickHit;
  assign level_up_OutHigh = (stateQ == StLevelUp);
  assign win_OutLow       = (stateQ != StWin);
  assign playing_OutHigh  = (stateQ == StPlaying) || (stateQ == StLevelUp);

endmodule

// File: tb/tb_frogger_level_sequencer.sv
// Self-checking bench for frogger_level_sequencer: directed scenarios then random play,
// every cycle compared against an elapsed-time reference model of the game rules.
module tb_frogger_level_sequencer;

  localparam int BasePeriod = 8;
  localparam int MaxLevel   = 3;

  localparam int ModeIdle  = 0;
  localparam int ModePlay  = 1;
  localparam int ModeLvlUp = 2;
  localparam int ModeWin   = 3;
  localparam int ModeOver  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       startN;
  logic       goal;
  logic       gameOverN;
  logic [1:0] level;
  logic       tick;
  logic       levelUp;
  logic       winN;
  logic       playing;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model
  int mMode;
  int mLevel;
  int mElapsed;
  bit mPrevStart;

  frogger_level_sequencer #(
    .LEVELS_DATAWIDTH   (2),
    .MAX_LEVEL          (MaxLevel),
    .PRESCALER_DATAWIDTH(24),
    .BASE_PERIOD        (BasePeriod)
  ) dut (
    .CLOCK_50        (clk),
    .RESET_InHigh    (rst),
    .start_InLow     (startN),
    .goal_InHigh     (goal),
    .game_over_InLow (gameOverN),
    .level_OutBUS    (level),
    .tick_OutHigh    (tick),
    .level_up_OutHigh(levelUp),
    .win_OutLow      (winN),
    .playing_OutHigh (playing)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed != expected) begin
      nFails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  function automatic int periodOf(input int lvl);
    int p;
    p = BasePeriod >> lvl;
    return (p == 0) ? 1 : p;
  endfunction

  task automatic modelReset();
    mMode      = ModeIdle;
    mLevel     = 0;
    mElapsed   = 0;
    mPrevStart = 1'b1;
  endtask

  task automatic modelStep(input bit s, input bit g, input bit o);
    bit ev;
    ev = !s && mPrevStart;
    mPrevStart = s;
    case (mMode)
      ModePlay: begin
        if (!o) mMode = ModeOver;
        else if (g && mLevel == MaxLevel) mMode = ModeWin;
        else if (g) begin
          mMode = ModeLvlUp;
          mLevel++;
        end else mElapsed++;
      end
      ModeLvlUp: begin
        mMode    = ModePlay;
        mElapsed = 0;
      end
      default: begin
        if (ev) begin
          mMode    = ModePlay;
          mLevel   = 0;
          mElapsed = 0;
        end
      end
    endcase
  endtask

  task automatic checkOutputs();
    int expTick;
    expTick = (mMode == ModePlay && ((mElapsed + 1) % periodOf(mLevel)) == 0) ? 1 : 0;
    checkVal("level", int'(level), mLevel);
    checkVal("tick", int'(tick), expTick);
    checkVal("levelUp", int'(levelUp), (mMode == ModeLvlUp) ? 1 : 0);
    checkVal("winN", int'(winN), (mMode == ModeWin) ? 0 : 1);
    checkVal("playing", int'(playing), (mMode == ModePlay || mMode == ModeLvlUp) ? 1 : 0);
  endtask

  task automatic cycle(input bit s, input bit g, input bit o);
    @(negedge clk);
    startN    = s;
    goal      = g;
    gameOverN = o;
    @(posedge clk);
    modelStep(s, g, o);
    #1 checkOutputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1);
  endtask

  task automatic pressStart(input int holdCycles);
    for (int i = 0; i < holdCycles; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
  endtask

  // Reset asserted between edges must clear outputs before any clock edge.
  task automatic midReset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutputs();
    @(negedge clk);
    startN    = 1'b1;
    goal      = 1'b0;
    gameOverN = 1'b1;
    rst       = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    startN    = 1'b1;
    goal      = 1'b0;
    gameOverN = 1'b1;
    modelReset();
    #1 checkOutputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Start held low: single event, level-0 cadence
    pressStart(20);
    idle(20);

    // Three level-ups, each followed by time to observe the faster cadence
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b1);
      idle(13);
    end
    // Goal at max level: win, then restart
    cycle(1'b1, 1'b1, 1'b1);
    idle(6);
    cycle(1'b1, 1'b1, 1'b1);
    idle(2);
    pressStart(3);
    idle(5);

    // Level 1 then collision: game over wins priority, later goal ignored
    cycle(1'b1, 1'b1, 1'b1);
    idle(5);
    cycle(1'b1, 1'b1, 1'b0);
    idle(4);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    idle(4);

    // Goal on two consecutive cycles: second lands in LEVEL_UP
    pressStart(2);
    idle(3);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    idle(6);

    // Reach level 2 and reset mid-cycle
    cycle(1'b1, 1'b1, 1'b1);
    idle(3);
    midReset();
    idle(3);

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      bit s, g, o;
      s = ($urandom_range(0, 11) != 0);
      g = ($urandom_range(0, 9) == 0);
      o = ($urandom_range(0, 59) != 0);
      cycle(s, g, o);
      if ($urandom_range(0, 999) == 0) midReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
